// File: rtl/branch_predict_unit_pkg.sv
// Types and encodings shared between the branch predictor and its clients.
package branch_predict_unit_pkg;
    import config_pkg::*;

    typedef enum logic [1:0] {
        SEL_BTB  = 2'b00,
        SEL_BHT  = 2'b01,
        SEL_RAS  = 2'b10,
        SEL_NONE = 2'b11
    } bp_sel_e;

    typedef enum logic [1:0] {
        RAS_PUSH    = 2'b00,
        RAS_POP     = 2'b01,
        RAS_POPPUSH = 2'b10,
        RAS_NONE    = 2'b11
    } ras_ctl_e;

    // Valid-only interfaces: a request is consumed in the cycle its valid is
    // high and there is no backpressure (no ready) anywhere in this unit.
    typedef struct packed {
        logic     valid;
        bp_sel_e  bp_ctl;
        ras_ctl_e ras_ctl;
    } bp_ctl_t;

    typedef struct packed {
        logic            valid;
        bp_sel_e         bp_update_ctl;
        logic [VLEN-1:0] vpc;
        logic [VLEN-1:0] addr;
    } updata_bp_t;

    typedef struct packed {
        logic            pred_valid;
        logic [VLEN-1:0] pred_add;
    } bp_result_t;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken && ctr != 2'b11) begin
            nxt = ctr + 2'b01;
        end else if (!taken && ctr != 2'b00) begin
            nxt = ctr - 2'b01;
        end
        return nxt;
    endfunction
endpackage

// File: rtl/config_pkg.sv
// Core-wide configuration shared by the fetch-side blocks.
package config_pkg;
    localparam int unsigned VLEN = 32;
endpackage

// File: rtl/branch_predict_unit_ras.sv
// Circular return-address stack: a push when full silently overwrites the oldest entry.
module ras
    import config_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [VLEN-1:0] data_i,
    output logic [VLEN-1:0] top_o,
    output logic            empty_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW + 1)'(DEPTH);

    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW:0]     cnt_q, cnt_d;
    logic [VLEN-1:0] stack_q [DEPTH];
    logic            we;
    logic [PW-1:0]   widx;
    logic [PW-1:0]   top_idx;

    // ptr_q names the next free slot, so the top lives one below it.
    assign top_idx = ptr_q - 1'b1;
    assign top_o   = stack_q[top_idx];
    assign empty_o = (cnt_q == '0);

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        we    = 1'b0;
        widx  = ptr_q;
        if (flush_i) begin
            ptr_d = '0;
            cnt_d = '0;
        end else if (push_i && pop_i && !empty_o) begin
            we   = 1'b1;
            widx = top_idx;
        end else if (push_i) begin
            we    = 1'b1;
            ptr_d = ptr_q + 1'b1;
            if (cnt_q != CNT_FULL) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (pop_i && !empty_o) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && we) begin
            stack_q[widx] <= data_i;
        end
    end
endmodule

// File: rtl/branch_predict_unit.sv
// Fetch-stage branch predictor: direct-mapped BTB, 2-bit BHT and a RAS, with a
// one-cycle registered prediction and backend-resolved table updates.
module branch_predict_unit
    import config_pkg::*;
    import branch_predict_unit_pkg::*;
#(
    parameter int unsigned BTB_ENTRIES = 16,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned RAS_DEPTH   = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic [VLEN-1:0] vpc_i,
    input  bp_ctl_t         bp_ctl_i,
    input  logic [VLEN-1:0] ret_addr_i,
    input  updata_bp_t      update_i,
    output bp_result_t      bp_result_o
);
    localparam int unsigned BTB_IW = $clog2(BTB_ENTRIES);
    localparam int unsigned BHT_IW = $clog2(BHT_ENTRIES);
    localparam int unsigned TAG_W  = VLEN - BTB_IW - 2;

    logic             btb_valid_q [BTB_ENTRIES];
    logic [TAG_W-1:0] btb_tag_q   [BTB_ENTRIES];
    logic [VLEN-1:0]  btb_tgt_q   [BTB_ENTRIES];
    logic [1:0]       bht_q       [BHT_ENTRIES];

    bp_result_t bp_result_q, bp_result_d;

    logic [BTB_IW-1:0] lk_btb_idx, up_btb_idx;
    logic [TAG_W-1:0]  lk_tag, up_tag;
    logic [BHT_IW-1:0] lk_bht_idx, up_bht_idx;
    logic              lk_btb_hit;
    logic              up_taken, btb_we, bht_we;
    logic              ras_push, ras_pop, ras_empty;
    logic [VLEN-1:0]   ras_top;
    logic              unused_vpc_lsb;

    assign unused_vpc_lsb = ^vpc_i[1:0];

    assign lk_btb_idx = vpc_i[BTB_IW+1:2];
    assign lk_tag     = vpc_i[VLEN-1:BTB_IW+2];
    assign lk_bht_idx = vpc_i[BHT_IW+1:2];
    assign lk_btb_hit = btb_valid_q[lk_btb_idx] && (btb_tag_q[lk_btb_idx] == lk_tag);

    assign up_btb_idx = update_i.vpc[BTB_IW+1:2];
    assign up_tag     = update_i.vpc[VLEN-1:BTB_IW+2];
    assign up_bht_idx = update_i.vpc[BHT_IW+1:2];
    assign up_taken   = (update_i.addr != (update_i.vpc + VLEN'(4)));

    // A taken conditional branch also teaches the BTB where it went.
    assign btb_we = update_i.valid && ((update_i.bp_update_ctl == SEL_BTB) ||
                                       (update_i.bp_update_ctl == SEL_BHT && up_taken));
    assign bht_we = update_i.valid && (update_i.bp_update_ctl == SEL_BHT);

    assign ras_push = bp_ctl_i.valid &&
                      (bp_ctl_i.ras_ctl == RAS_PUSH || bp_ctl_i.ras_ctl == RAS_POPPUSH);
    assign ras_pop  = bp_ctl_i.valid &&
                      (bp_ctl_i.ras_ctl == RAS_POP || bp_ctl_i.ras_ctl == RAS_POPPUSH);

    ras #(
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (ras_push),
        .pop_i   (ras_pop),
        .data_i  (ret_addr_i),
        .top_o   (ras_top),
        .empty_o (ras_empty)
    );

    always_comb begin
        bp_result_d = '0;
        if (bp_ctl_i.valid && !flush_i) begin
            unique case (bp_ctl_i.bp_ctl)
                SEL_BTB: begin
                    if (lk_btb_hit) begin
                        bp_result_d.pred_valid = 1'b1;
                        bp_result_d.pred_add   = btb_tgt_q[lk_btb_idx];
                    end
                end
                SEL_BHT: begin
                    if (lk_btb_hit && bht_q[lk_bht_idx][1]) begin
                        bp_result_d.pred_valid = 1'b1;
                        bp_result_d.pred_add   = btb_tgt_q[lk_btb_idx];
                    end
                end
                SEL_RAS: begin
                    if (ras_pop && !ras_empty) begin
                        bp_result_d.pred_valid = 1'b1;
                        bp_result_d.pred_add   = ras_top;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bp_result_q <= '0;
        end else begin
            bp_result_q <= bp_result_d;
        end
    end

    assign bp_result_o = bp_result_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid_q[i] <= 1'b0;
            end
        end else if (btb_we) begin
            btb_valid_q[up_btb_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && btb_we) begin
            btb_tag_q[up_btb_idx] <= up_tag;
            btb_tgt_q[up_btb_idx] <= update_i.addr;
        end
    end

    // Counters come out of reset weakly not-taken.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (bht_we) begin
            bht_q[up_bht_idx] <= ctr_next(bht_q[up_bht_idx], up_taken);
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit with a table/queue-level reference model.
module tb_branch_predict_unit;
    import config_pkg::*;
    import branch_predict_unit_pkg::*;

    localparam int BTB_N = 16;
    localparam int BHT_N = 64;
    localparam int RAS_D = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [VLEN-1:0] vpc;
    bp_ctl_t         ctl;
    logic [VLEN-1:0] ret;
    updata_bp_t      upd;
    bp_result_t      bp_result_o;

    int checks = 0;
    int errors = 0;

    branch_predict_unit #(
        .BTB_ENTRIES (BTB_N),
        .BHT_ENTRIES (BHT_N),
        .RAS_DEPTH   (RAS_D)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .vpc_i       (vpc),
        .bp_ctl_i    (ctl),
        .ret_addr_i  (ret),
        .update_i    (upd),
        .bp_result_o (bp_result_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference model: tables as plain arrays, RAS as a bounded queue
    bit              m_btb_v   [BTB_N];
    logic [VLEN-1:0] m_btb_pc  [BTB_N];
    logic [VLEN-1:0] m_btb_tgt [BTB_N];
    int              m_ctr     [BHT_N];
    logic [VLEN-1:0] m_ras     [$];
    logic [VLEN:0]   exp_q     [$];

    function automatic int btb_slot(input logic [VLEN-1:0] pc);
        return int'((pc >> 2) % BTB_N);
    endfunction

    function automatic bit m_hit(input logic [VLEN-1:0] pc);
        int s;
        s = btb_slot(pc);
        return m_btb_v[s] && ((m_btb_pc[s] >> 2) / BTB_N == (pc >> 2) / BTB_N);
    endfunction

    always @(posedge clk) begin
        logic [VLEN:0] e;
        int s;
        int c;
        bit taken;
        e = '0;
        if (rst) begin
            for (int i = 0; i < BTB_N; i++) m_btb_v[i] = 1'b0;
            for (int i = 0; i < BHT_N; i++) m_ctr[i] = 1;
            m_ras.delete();
        end else begin
            if (ctl.valid && !flush) begin
                s = btb_slot(vpc);
                c = int'((vpc >> 2) % BHT_N);
                if (ctl.bp_ctl == SEL_BTB && m_hit(vpc)) e = {1'b1, m_btb_tgt[s]};
                if (ctl.bp_ctl == SEL_BHT && m_hit(vpc) && m_ctr[c] >= 2) e = {1'b1, m_btb_tgt[s]};
                if (ctl.bp_ctl == SEL_RAS && m_ras.size() > 0 &&
                    (ctl.ras_ctl == RAS_POP || ctl.ras_ctl == RAS_POPPUSH)) e = {1'b1, m_ras[$]};
                if (ctl.ras_ctl == RAS_PUSH || (ctl.ras_ctl == RAS_POPPUSH && m_ras.size() == 0)) begin
                    m_ras.push_back(ret);
                    if (m_ras.size() > RAS_D) void'(m_ras.pop_front());
                end else if (ctl.ras_ctl == RAS_POPPUSH) begin
                    m_ras[m_ras.size() - 1] = ret;
                end else if (ctl.ras_ctl == RAS_POP && m_ras.size() > 0) begin
                    void'(m_ras.pop_back());
                end
            end
            if (flush) m_ras.delete();
            if (upd.valid) begin
                s = btb_slot(upd.vpc);
                c = int'((upd.vpc >> 2) % BHT_N);
                taken = (upd.addr != upd.vpc + 32'd4);
                if (upd.bp_update_ctl == SEL_BHT) m_ctr[c] = taken ? ((m_ctr[c] < 3) ? m_ctr[c] + 1 : 3)
                                                                   : ((m_ctr[c] > 0) ? m_ctr[c] - 1 : 0);
                if (upd.bp_update_ctl == SEL_BTB || (upd.bp_update_ctl == SEL_BHT && taken)) begin
                    m_btb_v[s]   = 1'b1;
                    m_btb_pc[s]  = upd.vpc;
                    m_btb_tgt[s] = upd.addr;
                end
            end
        end
        exp_q.push_back(e);
    end

    // scoreboard: every registered output checked against the model
    always @(negedge clk) begin
        logic [VLEN:0] e;
        logic [VLEN:0] got;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = bp_result_o;
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL model_cmp t=%0t got pv=%0b pa=0x%h expected pv=%0b pa=0x%h",
                         $time, got[VLEN], got[VLEN-1:0], e[VLEN], e[VLEN-1:0]);
            end
        end
    end

    // driver tasks
    task automatic set_idle();
        ctl   = '{valid: 1'b0, bp_ctl: SEL_NONE, ras_ctl: RAS_NONE};
        vpc   = '0;
        ret   = '0;
        upd   = '0;
        flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        set_idle();
    endtask

    task automatic lk(input bp_sel_e s, input ras_ctl_e r, input logic [VLEN-1:0] pc,
                      input logic [VLEN-1:0] ra);
        ctl = '{valid: 1'b1, bp_ctl: s, ras_ctl: r};
        vpc = pc;
        ret = ra;
        tick();
    endtask

    task automatic up(input bp_sel_e s, input logic [VLEN-1:0] pc, input logic [VLEN-1:0] a);
        upd = '{valid: 1'b1, bp_update_ctl: s, vpc: pc, addr: a};
        tick();
    endtask

    task automatic expect_res(input string name, input logic pv, input logic [VLEN-1:0] pa);
        checks++;
        if (bp_result_o.pred_valid !== pv || bp_result_o.pred_add !== pa) begin
            errors++;
            $display("FAIL %s: got pv=%0b pa=0x%h expected pv=%0b pa=0x%h",
                     name, bp_result_o.pred_valid, bp_result_o.pred_add, pv, pa);
        end
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        expect_res("reset_out", 1'b0, 32'h0);

        lk(SEL_BHT, RAS_NONE, 32'h1000, 32'h0);
        expect_res("bht_cold", 1'b0, 32'h0);

        up(SEL_BTB, 32'h1000, 32'h2000);
        lk(SEL_BTB, RAS_NONE, 32'h1000, 32'h0);
        expect_res("btb_hit", 1'b1, 32'h2000);
        lk(SEL_BTB, RAS_NONE, 32'h1040, 32'h0);
        expect_res("btb_tag_miss", 1'b0, 32'h0);

        // lookup and update on the same slot in one cycle
        upd = '{valid: 1'b1, bp_update_ctl: SEL_BTB, vpc: 32'h1080, addr: 32'h5000};
        lk(SEL_BTB, RAS_NONE, 32'h1000, 32'h0);
        expect_res("same_cycle_old", 1'b1, 32'h2000);
        lk(SEL_BTB, RAS_NONE, 32'h1000, 32'h0);
        expect_res("evicted", 1'b0, 32'h0);
        lk(SEL_BTB, RAS_NONE, 32'h1080, 32'h0);
        expect_res("new_tag", 1'b1, 32'h5000);

        up(SEL_BHT, 32'h1000, 32'h3000);
        up(SEL_BHT, 32'h1000, 32'h3000);
        lk(SEL_BHT, RAS_NONE, 32'h1000, 32'h0);
        expect_res("bht_taken", 1'b1, 32'h3000);
        up(SEL_BHT, 32'h1000, 32'h1004);
        up(SEL_BHT, 32'h1000, 32'h1004);
        lk(SEL_BHT, RAS_NONE, 32'h1000, 32'h0);
        expect_res("bht_not_taken", 1'b0, 32'h0);
        // floor at 00: two more not-taken then two taken must reach 10
        up(SEL_BHT, 32'h1000, 32'h1004);
        up(SEL_BHT, 32'h1000, 32'h1004);
        up(SEL_BHT, 32'h1000, 32'h3000);
        lk(SEL_BHT, RAS_NONE, 32'h1000, 32'h0);
        expect_res("bht_weak_nt", 1'b0, 32'h0);
        up(SEL_BHT, 32'h1000, 32'h3000);
        lk(SEL_BHT, RAS_NONE, 32'h1000, 32'h0);
        expect_res("bht_sat_low", 1'b1, 32'h3000);
        up(SEL_RAS, 32'h1000, 32'h9000);
        lk(SEL_BTB, RAS_NONE, 32'h1000, 32'h0);
        expect_res("upd_sel10_noop", 1'b1, 32'h3000);

        lk(SEL_RAS, RAS_PUSH, 32'h0, 32'h10);
        expect_res("ras_push_nopred", 1'b0, 32'h0);
        lk(SEL_NONE, RAS_PUSH, 32'h0, 32'h20);
        lk(SEL_RAS, RAS_POP, 32'h0, 32'h0);
        expect_res("ras_pop1", 1'b1, 32'h20);
        lk(SEL_RAS, RAS_POP, 32'h0, 32'h0);
        expect_res("ras_pop2", 1'b1, 32'h10);
        lk(SEL_RAS, RAS_POP, 32'h0, 32'h0);
        expect_res("ras_pop_empty", 1'b0, 32'h0);

        for (int k = 1; k <= 9; k++) lk(SEL_NONE, RAS_PUSH, 32'h0, VLEN'(k * 256));
        for (int k = 9; k >= 2; k--) begin
            lk(SEL_RAS, RAS_POP, 32'h0, 32'h0);
            expect_res("ras_wrap_pop", 1'b1, VLEN'(k * 256));
        end
        lk(SEL_RAS, RAS_POP, 32'h0, 32'h0);
        expect_res("ras_wrap_empty", 1'b0, 32'h0);

        lk(SEL_NONE, RAS_PUSH, 32'h0, 32'hA0);
        lk(SEL_RAS, RAS_POPPUSH, 32'h0, 32'hB0);
        expect_res("ras_poppush", 1'b1, 32'hA0);
        lk(SEL_RAS, RAS_POP, 32'h0, 32'h0);
        expect_res("ras_replaced", 1'b1, 32'hB0);
        lk(SEL_RAS, RAS_POPPUSH, 32'h0, 32'hC0);
        expect_res("ras_poppush_empty", 1'b0, 32'h0);
        lk(SEL_RAS, RAS_POP, 32'h0, 32'h0);
        expect_res("ras_poppush_as_push", 1'b1, 32'hC0);

        lk(SEL_NONE, RAS_PUSH, 32'h0, 32'h40);
        flush = 1'b1;
        upd = '{valid: 1'b1, bp_update_ctl: SEL_BTB, vpc: 32'h2000, addr: 32'h7000};
        lk(SEL_RAS, RAS_POP, 32'h0, 32'h0);
        expect_res("flush_pop", 1'b0, 32'h0);
        lk(SEL_RAS, RAS_POP, 32'h0, 32'h0);
        expect_res("after_flush_pop", 1'b0, 32'h0);
        lk(SEL_BTB, RAS_NONE, 32'h2000, 32'h0);
        expect_res("flush_keeps_update", 1'b1, 32'h7000);

        // reset in the middle of traffic
        lk(SEL_NONE, RAS_PUSH, 32'h0, 32'h55);
        rst = 1'b1;
        upd = '{valid: 1'b1, bp_update_ctl: SEL_BTB, vpc: 32'h3000, addr: 32'h8000};
        lk(SEL_BTB, RAS_NONE, 32'h2000, 32'h0);
        rst = 1'b0;
        expect_res("mid_reset_out", 1'b0, 32'h0);
        lk(SEL_BTB, RAS_NONE, 32'h2000, 32'h0);
        expect_res("reset_clears_btb", 1'b0, 32'h0);
        lk(SEL_BTB, RAS_NONE, 32'h3000, 32'h0);
        expect_res("reset_drops_update", 1'b0, 32'h0);
        lk(SEL_RAS, RAS_POP, 32'h0, 32'h0);
        expect_res("reset_clears_ras", 1'b0, 32'h0);

        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter BTB_ENTRIES, default 16, meaning direct-mapped BTB entries (power of 2).
REQ-002 SHALL have parameter BHT_ENTRIES, default 64, meaning 2-bit counter entries (power of 2).
REQ-003 SHALL have parameter RAS_DEPTH, default 8, meaning return-address-stack entries (power of 2).
REQ-004 SHALL have port clk_i  input  1  clock, single clock domain, all state on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port flush_i  input  1  pipeline flush; squashes current lookup, clears RAS.
REQ-007 SHALL have port vpc_i  input  VLEN  fetch PC of looked-up instruction.
REQ-008 SHALL have port bp_ctl_i  input  bp_ctl_t  lookup request: valid, bp_ctl_i selector (00 BTB, 01 BHT, 10 RAS, 11 none), ras_ctl (00 push, 01 pop, 10 pop+push, 11 none).
REQ-009 SHALL have port ret_addr_i  input  VLEN  return address pushed on RAS push.
REQ-010 SHALL have port update_i  input  updata_bp_t  resolved-branch update from backend: valid, bp_update_ctl, vpc, addr (resolved next PC).
REQ-011 SHALL have port bp_result_o  output  bp_result_t  registered prediction: pred_valid, pred_add.

Function
REQ-012 SHALL register bp_result_o: result for a lookup with bp_ctl_i.valid=1 in cycle N appears in cycle N+1 only; pred_valid=0 in all other cycles.
REQ-013 SHALL index BTB with vpc[log2(BTB_ENTRIES)+1:2], tag with remaining upper bits; each entry holds valid, tag, target.
REQ-014 Selector 00: pred_valid = BTB valid and tag match; pred_add = stored target, else 0.
REQ-015 SHALL index BHT with vpc[log2(BHT_ENTRIES)+1:2]; counters saturate at 00 and 11.
REQ-016 Selector 01: pred_valid = counter[1] and BTB hit; pred_add = BTB target, else 0.
REQ-017 Selector 10: pred_valid = RAS non-empty and ras_ctl in {01,10}; pred_add = top-of-stack value before the pop.
REQ-018 Selector 11: pred_valid=0; RAS action per ras_ctl still executes.
REQ-019 RAS push writes ret_addr_i above top; full push overwrites oldest entry (circular), count stays RAS_DEPTH.
REQ-020 RAS pop on empty: no state change, pred_valid=0; pop+push on empty equals plain push.
REQ-021 Pop+push (10) replaces top with ret_addr_i in one cycle; count unchanged when non-empty.
REQ-022 update_i with selector 00: write BTB entry (valid=1, tag, target=addr) at vpc index.
REQ-023 update_i with selector 01: taken = (addr != vpc+4); counter +1 if taken else -1 (saturating); when taken also write BTB as REQ-022.
REQ-024 update_i with selector 10 or 11: no table change.
REQ-025 Lookup and update in same cycle to same index: lookup reads pre-update contents; update takes effect next cycle.
REQ-026 flush_i=1: bp_result_o.pred_valid=0 next cycle, RAS count and pointer to 0, the same-cycle ras_ctl ignored; BTB/BHT updates in that cycle still applied.

Reset
REQ-027 On rst_i=1 at a clock edge: all BTB valid bits 0, all BHT counters 01 (weakly not-taken), RAS count 0 and pointer 0, bp_result_o all zeros.
REQ-028 Reset asserted mid-operation SHALL discard in-flight lookup and same-cycle update; reset overrides flush_i and update_i.

Structure
REQ-029 bp_ctl_t, updata_bp_t, bp_result_t and selector/ras_ctl encodings SHALL live in the shared package; VLEN from config_pkg.
REQ-030 The RAS SHALL be a sub-module named ras (push/pop/pop+push, flush, top, empty).
REQ-031 BTB and BHT SHALL be flop arrays in branch_predict_unit; no SRAM macros.

Verification
REQ-032 After reset, lookup vpc=0x1000 selector 01 -> next cycle pred_valid=0, pred_add=0.
REQ-033 Update selector 00 vpc=0x1000 addr=0x2000, then lookup vpc=0x1000 selector 00 -> pred_valid=1, pred_add=0x2000; lookup vpc=0x1040 (same index, other tag) -> pred_valid=0.
REQ-034 Two BHT updates vpc=0x1000 addr=0x3000 (taken), then lookup selector 01 -> pred_valid=1, pred_add=0x3000; two updates addr=0x1004 -> pred_valid=0.
REQ-035 Push 0x10,0x20 then pop -> pred_add=0x20; pop -> 0x10; third pop -> pred_valid=0.
REQ-036 Push 9 values 0x100..0x900 with RAS_DEPTH=8 then 8 pops -> 0x900 down to 0x200; 9th pop pred_valid=0.
REQ-037 Push 0x40 then pop with flush_i=1 same cycle -> pred_valid=0 next cycle, subsequent pop pred_valid=0.
